fpu_cvt_wb: RTL and testbench
=============================

// Module: fpu_cvt_wb
// PURPOSE
//  Writeback/retire stage directly downstream of the int-to-float converter (FCVT.S.W/WU).
//  Buffers converted results with destination tag and inexact flag, presents them to the FP
//  register-file write port with valid/ready, accumulates sticky fflags for the CSR unit and
//  exports a per-register pending bitmap for hazard checks in the issue logic.
// PARAMETERS
//  DEPTH   2   result buffer entries (power of 2, >=2)
//  TAG_W   5   destination register index width
// PORTS
//  clk_i           in   1      clock, rising edge
//  reset_i         in   1      asynchronous, active-low reset
//  in_valid_i      in   1      converter result valid
//  in_ready_o      out  1      stage can accept (= !full)
//  in_result_i     in   32     IEEE-754 single result from converter
//  in_rd_i         in   TAG_W  destination FP register
//  in_nx_i         in   1      inexact (any of G/R/S set before rounding)
//  wb_valid_o      out  1      head entry valid
//  wb_ready_i      in   1      register file accepts write
//  wb_data_o       out  32     head result
//  wb_rd_o         out  TAG_W  head destination
//  flush_i         in   1      pipeline flush: discard all buffered entries
//  fflags_we_i     in   1      CSR write to fflags
//  fflags_wdata_i  in   5      CSR write data {NV,DZ,OF,UF,NX}
//  fflags_o        out  5      current sticky flags
//  rd_pending_o    out  2^TAG_W bit r set while any buffered entry targets register r
//  busy_o          out  1      buffer non-empty
// BEHAVIOUR
//  - Reset (async, reset_i=0): count, pointers, entries, fflags_o cleared; wb_valid_o=0,
//    in_ready_o=1 once reset releases; wb_data_o/wb_rd_o=0; rd_pending_o=0.
//  - Circular buffer, wr_ptr/rd_ptr wrap modulo DEPTH; count 0..DEPTH.
//  - push = in_valid_i & in_ready_o & !flush_i; pop = wb_valid_o & wb_ready_i & !flush_i.
//  - in_ready_o = (count != DEPTH); no same-cycle pop-to-push bypass when full.
//  - Latency: entry pushed in cycle N is visible on wb_* in cycle N+1 (registered head).
//  - wb_valid_o = (count != 0); wb_data_o/wb_rd_o held stable while wb_valid_o & !wb_ready_i.
//  - Simultaneous push and pop (not full): count unchanged, both pointers advance.
//  - Order preserved: FIFO, one retire per cycle max.
//  - fflags: on pop, fflags[0] |= head nx. CSR write wins then retiring nx ORed in same cycle:
//    fflags <= fflags_wdata_i | {4'b0, pop & head_nx}. Bits [4:1] only change via CSR write.
//  - flush_i: next cycle count=0, pointers=0, wb_valid_o=0; push and pop suppressed that cycle;
//    fflags not updated by flushed entries; CSR write still honoured.
//  - rd_pending_o: combinational OR of one-hot(rd) over valid entries; duplicate tags allowed,
//    bit clears only when last matching entry pops or flush.
//  - in_valid_i while !in_ready_o: no state change; upstream must hold data.
//  - Reset asserted mid-operation: immediate clear, buffered results lost, no fflags update.
// STRUCTURE
//  - Shared package fpu_defs: FFLAG_W=5, bit indices FFLAG_NX=0, UF=1, OF=2, DZ=3, NV=4,
//    FP register tag width.
//  - One sub-module: fpu_wb_fifo (parametric DEPTH x (32+TAG_W+1) storage, ptrs, count,
//    full/empty, async active-low reset). Top holds fflags reg and pending-bitmap decode.
// TESTING
//  1 push 0x3F800000 rd=3 nx=0, wb_ready=1 -> cycle+1 wb_valid=1 data=0x3F800000 rd=3;
//    rd_pending[3]=1 until pop; fflags stays 0.
//  2 wb_ready=0, push rd=1 nx=1 then rd=2 nx=0 -> in_ready=0 after 2nd; 3rd push stalls;
//    release ready -> pops rd1, rd2 in order; fflags=5'b00001 after first pop.
//  3 pop nx=1 same cycle as CSR write 5'b10000 -> fflags=5'b10001.
//  4 two entries rd=7 buffered, flush_i=1 with in_valid=1 -> next cycle busy=0,
//    rd_pending=0, fflags unchanged, pushed item dropped.
//  5 steady push+pop every cycle for 20 results -> no bubbles, count constant, ptrs wrap.
//  6 reset_i low mid-stream with count=2 -> outputs zero immediately, asynchronous to clk_i.

Source files
------------

// File: rtl/fpu_defs.sv
// Shared FP definitions: fflags layout, register tag width and a flag helper.
package fpu_defs;
    localparam int FFLAG_W    = 5;
    localparam int FFLAG_NX   = 0;
    localparam int FFLAG_UF   = 1;
    localparam int FFLAG_OF   = 2;
    localparam int FFLAG_DZ   = 3;
    localparam int FFLAG_NV   = 4;
    localparam int FREG_TAG_W = 5;
    localparam int FP_W       = 32;

    function automatic logic [FFLAG_W-1:0] nx_flag(input logic nx);
        logic [FFLAG_W-1:0] f;
        f           = '0;
        f[FFLAG_NX] = nx;
        return f;
    endfunction
endpackage

// File: rtl/fpu_wb_fifo.sv
// Circular result buffer: DEPTH entries of {data, tag, nx}, exposes head and per-entry tags/valids.
module fpu_wb_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic [TAG_W-1:0]             wtag_i,
    input  logic                         wnx_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic [TAG_W-1:0]             rtag_o,
    output logic                         rnx_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [DEPTH-1:0][TAG_W-1:0]  tags_o,
    output logic [DEPTH-1:0]             vld_o
);
    localparam int EW    = DATA_W + TAG_W + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][EW-1:0] r_mem;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_cnt;

    // Flush has priority over push/pop; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (push_i) begin
                r_mem[r_wr_ptr] <= {wdata_i, wtag_i, wnx_i};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (pop_i)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt <= r_cnt + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign rdata_o = r_mem[r_rd_ptr][EW-1 -: DATA_W];
    assign rtag_o  = r_mem[r_rd_ptr][TAG_W:1];
    assign rnx_o   = r_mem[r_rd_ptr][0];
    assign full_o  = (r_cnt == CNT_W'(DEPTH));
    assign empty_o = (r_cnt == '0);

    // An entry is live when its distance from the read pointer is below the count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_vld
        logic [PTR_W-1:0] w_off;
        assign w_off     = PTR_W'(g) - r_rd_ptr;
        assign vld_o[g]  = (CNT_W'(w_off) < r_cnt);
        assign tags_o[g] = r_mem[g][TAG_W:1];
    end
endmodule

// File: rtl/fpu_cvt_wb.sv
// Int-to-float converter writeback stage: result buffer, sticky fflags, pending-register bitmap.
module fpu_cvt_wb
    import fpu_defs::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = FREG_TAG_W
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [FP_W-1:0]         in_result_i,
    input  logic [TAG_W-1:0]        in_rd_i,
    input  logic                    in_nx_i,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [FP_W-1:0]         wb_data_o,
    output logic [TAG_W-1:0]        wb_rd_o,
    input  logic                    flush_i,
    input  logic                    fflags_we_i,
    input  logic [FFLAG_W-1:0]      fflags_wdata_i,
    output logic [FFLAG_W-1:0]      fflags_o,
    output logic [(1<<TAG_W)-1:0]   rd_pending_o,
    output logic                    busy_o
);
    logic                         w_push, w_pop, w_full, w_empty, w_head_nx;
    logic [DEPTH-1:0][TAG_W-1:0]  w_tags;
    logic [DEPTH-1:0]             w_vld;
    logic [FFLAG_W-1:0]           r_fflags;

    assign w_push = in_valid_i & ~w_full & ~flush_i;
    assign w_pop  = ~w_empty & wb_ready_i & ~flush_i;

    fpu_wb_fifo #(.DEPTH(DEPTH), .DATA_W(FP_W), .TAG_W(TAG_W)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (flush_i),
        .wdata_i (in_result_i),
        .wtag_i  (in_rd_i),
        .wnx_i   (in_nx_i),
        .rdata_o (wb_data_o),
        .rtag_o  (wb_rd_o),
        .rnx_o   (w_head_nx),
        .full_o  (w_full),
        .empty_o (w_empty),
        .tags_o  (w_tags),
        .vld_o   (w_vld)
    );

    assign in_ready_o = ~w_full;
    assign wb_valid_o = ~w_empty;
    assign busy_o     = ~w_empty;

    // CSR write replaces the flags, but a result retiring that cycle still contributes NX.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            r_fflags <= '0;
        else if (fflags_we_i)
            r_fflags <= fflags_wdata_i | nx_flag(w_pop & w_head_nx);
        else
            r_fflags <= r_fflags | nx_flag(w_pop & w_head_nx);
    end
    assign fflags_o = r_fflags;

    always_comb begin
        rd_pending_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (w_vld[i])
                rd_pending_o[w_tags[i]] = 1'b1;
    end
endmodule

// File: tb/tb_fpu_cvt_wb.sv
// Directed bench for fpu_cvt_wb: cycle table plus streaming and async-reset sequences.
module tb_fpu_cvt_wb;
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_result_i = '0;
    logic [4:0]  in_rd_i = '0;
    logic        in_nx_i = 1'b0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        flush_i = 1'b0;
    logic        fflags_we_i = 1'b0;
    logic [4:0]  fflags_wdata_i = '0;
    logic [4:0]  fflags_o;
    logic [31:0] rd_pending_o;
    logic        busy_o;

    int n_pass = 0;
    int n_total = 0;

    fpu_cvt_wb #(.DEPTH(2), .TAG_W(5)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_result_i(in_result_i),
        .in_rd_i(in_rd_i), .in_nx_i(in_nx_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
        .flush_i(flush_i), .fflags_we_i(fflags_we_i), .fflags_wdata_i(fflags_wdata_i),
        .fflags_o(fflags_o), .rd_pending_o(rd_pending_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        vld;  logic [31:0] res;  logic [4:0] rd;  logic nx;
        logic        rdy;  logic        fl;   logic       we;  logic [4:0] wd;
        logic        e_val; logic [31:0] e_data; logic [4:0] e_rd; logic e_rdy;
        logic [4:0]  e_ff; logic [31:0] e_pend;
    } vec_t;

    function automatic vec_t mk(logic vld, logic [31:0] res, logic [4:0] rd, logic nx,
                                logic rdy, logic fl, logic we, logic [4:0] wd,
                                logic e_val, logic [31:0] e_data, logic [4:0] e_rd,
                                logic e_rdy, logic [4:0] e_ff, logic [31:0] e_pend);
        vec_t v;
        v.vld = vld; v.res = res; v.rd = rd; v.nx = nx;
        v.rdy = rdy; v.fl = fl; v.we = we; v.wd = wd;
        v.e_val = e_val; v.e_data = e_data; v.e_rd = e_rd;
        v.e_rdy = e_rdy; v.e_ff = e_ff; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic vld, input logic [31:0] res, input logic [4:0] rd,
                         input logic nx, input logic rdy, input logic fl,
                         input logic we, input logic [4:0] wd);
        in_valid_i = vld; in_result_i = res; in_rd_i = rd; in_nx_i = nx;
        wb_ready_i = rdy; flush_i = fl; fflags_we_i = we; fflags_wdata_i = wd;
    endtask

    vec_t vt[18];

    initial begin
        // Each row: inputs for one cycle, then the outputs expected after that edge.
        vt[0]  = mk(1, 32'h3F800000, 3, 0, 1, 0, 0, 5'h00, 1, 32'h3F800000, 3, 1, 5'h00, 32'h0000_0008);
        vt[1]  = mk(0, 32'h0,        0, 0, 1, 0, 0, 5'h00, 0, 32'h0,        0, 1, 5'h00, 32'h0);
        vt[2]  = mk(1, 32'h40000000, 1, 1, 0, 0, 0, 5'h00, 1, 32'h40000000, 1, 1, 5'h00, 32'h0000_0002);
        vt[3]  = mk(1, 32'h40400000, 2, 0, 0, 0, 0, 5'h00, 1, 32'h40000000, 1, 0, 5'h00, 32'h0000_0006);
        vt[4]  = mk(1, 32'h40800000, 4, 0, 0, 0, 0, 5'h00, 1, 32'h40000000, 1, 0, 5'h00, 32'h0000_0006);
        vt[5]  = mk(1, 32'h40800000, 4, 0, 1, 0, 0, 5'h00, 1, 32'h40400000, 2, 1, 5'h01, 32'h0000_0004);
        vt[6]  = mk(1, 32'h40800000, 4, 0, 1, 0, 0, 5'h00, 1, 32'h40800000, 4, 1, 5'h01, 32'h0000_0010);
        vt[7]  = mk(0, 32'h0,        0, 0, 1, 0, 0, 5'h00, 0, 32'h0,        0, 1, 5'h01, 32'h0);
        vt[8]  = mk(1, 32'h3F000000, 5, 1, 0, 0, 1, 5'h00, 1, 32'h3F000000, 5, 1, 5'h00, 32'h0000_0020);
        vt[9]  = mk(0, 32'h0,        0, 0, 1, 0, 1, 5'h10, 0, 32'h0,        0, 1, 5'h11, 32'h0);
        vt[10] = mk(1, 32'h41000000, 7, 1, 0, 0, 1, 5'h00, 1, 32'h41000000, 7, 1, 5'h00, 32'h0000_0080);
        vt[11] = mk(1, 32'h41100000, 7, 0, 0, 0, 0, 5'h00, 1, 32'h41000000, 7, 0, 5'h00, 32'h0000_0080);
        vt[12] = mk(1, 32'h41200000, 9, 1, 1, 1, 0, 5'h00, 0, 32'h0,        0, 1, 5'h00, 32'h0);
        vt[13] = mk(1, 32'h41300000,10, 0, 1, 1, 1, 5'h04, 0, 32'h0,        0, 1, 5'h04, 32'h0);
        vt[14] = mk(1, 32'h00000001, 7, 0, 0, 0, 0, 5'h00, 1, 32'h00000001, 7, 1, 5'h04, 32'h0000_0080);
        vt[15] = mk(1, 32'h00000002, 7, 1, 0, 0, 0, 5'h00, 1, 32'h00000001, 7, 0, 5'h04, 32'h0000_0080);
        vt[16] = mk(0, 32'h0,        0, 0, 1, 0, 0, 5'h00, 1, 32'h00000002, 7, 1, 5'h04, 32'h0000_0080);
        vt[17] = mk(0, 32'h0,        0, 0, 1, 0, 0, 5'h00, 0, 32'h0,        0, 1, 5'h05, 32'h0);

        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rst.wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst.in_ready", 32'(in_ready_o), 32'd1);
        chk("rst.wb_data", wb_data_o, 32'd0);
        chk("rst.wb_rd", 32'(wb_rd_o), 32'd0);
        chk("rst.fflags", 32'(fflags_o), 32'd0);
        chk("rst.pending", rd_pending_o, 32'd0);
        chk("rst.busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].vld, vt[i].res, vt[i].rd, vt[i].nx, vt[i].rdy, vt[i].fl, vt[i].we, vt[i].wd);
            @(posedge clk_i); #1;
            chk($sformatf("v%0d.wb_valid", i), 32'(wb_valid_o), 32'(vt[i].e_val));
            chk($sformatf("v%0d.busy", i), 32'(busy_o), 32'(vt[i].e_val));
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready_o), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d.fflags", i), 32'(fflags_o), 32'(vt[i].e_ff));
            chk($sformatf("v%0d.pending", i), rd_pending_o, vt[i].e_pend);
            if (vt[i].e_val) begin
                chk($sformatf("v%0d.wb_data", i), wb_data_o, vt[i].e_data);
                chk($sformatf("v%0d.wb_rd", i), 32'(wb_rd_o), 32'(vt[i].e_rd));
            end
        end

        // Streaming: one entry primed, then push+pop every cycle keeps the head advancing.
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        chk("str.prime", wb_data_o, 32'h100);
        for (int k = 1; k <= 20; k++) begin
            drive(1, 32'h100 + 32'(k), 5'(k), 0, 1, 0, 0, 0);
            @(posedge clk_i); #1;
            chk($sformatf("str%0d.wb_valid", k), 32'(wb_valid_o), 32'd1);
            chk($sformatf("str%0d.in_ready", k), 32'(in_ready_o), 32'd1);
            chk($sformatf("str%0d.wb_data", k), wb_data_o, 32'h100 + 32'(k));
            chk($sformatf("str%0d.pending", k), rd_pending_o, 32'd1 << k);
        end
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        @(posedge clk_i); #1;
        chk("str.drain", 32'(wb_valid_o), 32'd0);

        // Async reset mid-cycle with two buffered entries and all flags set.
        drive(1, 32'hAAAA5555, 6, 1, 0, 0, 1, 5'h1F);
        @(posedge clk_i); #1;
        drive(1, 32'h5555AAAA, 8, 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        chk("ar.pre_full", 32'(in_ready_o), 32'd0);
        chk("ar.pre_ff", 32'(fflags_o), 32'h1F);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset_i = 1'b0;
        #1;
        chk("ar.wb_valid", 32'(wb_valid_o), 32'd0);
        chk("ar.busy", 32'(busy_o), 32'd0);
        chk("ar.wb_data", wb_data_o, 32'd0);
        chk("ar.wb_rd", 32'(wb_rd_o), 32'd0);
        chk("ar.fflags", 32'(fflags_o), 32'd0);
        chk("ar.pending", rd_pending_o, 32'd0);
        chk("ar.in_ready", 32'(in_ready_o), 32'd1);
        #2 reset_i = 1'b1;
        @(posedge clk_i); #1;
        chk("ar.post_valid", 32'(wb_valid_o), 32'd0);
        chk("ar.post_ready", 32'(in_ready_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
